eq_mix_engine: RTL

//  Parametrised successor to the fixed 5-band stereo gain/sum stage of the equalizer core.

---
 rtl/eq_mix_engine_pkg.sv | 44 ++++
 rtl/eq_mix_engine_sat_mul.sv | 44 ++++
 rtl/eq_mix_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/eq_mix_engine_pkg.sv
// Shared types and arithmetic helpers for the band-mix engine.
// Saturation works on a 64-bit carrier so one helper serves every width.
package eq_mix_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_VOL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int XW = 64;

    function automatic int acc_width(input int dw, input int n_bands);
        return dw + $clog2(n_bands) + 2;
    endfunction

    function automatic int smpl_idx(input int ch, input int b, input int n_bands);
        return ch * n_bands + b;
    endfunction

    function automatic logic signed [XW-1:0] sat_to(input logic signed [XW-1:0] v, input int w);
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    function automatic logic clip_to(input logic signed [XW-1:0] v, input int w);
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/eq_mix_engine_sat_mul.sv
// Shared signed x unsigned multiplier with mode-selected arithmetic shift.
// Band mode yields the raw accumulator term; volume mode yields a saturated sample.
module eq_mix_engine_sat_mul
    import eq_mix_engine_pkg::*;
#(
    parameter int DW   = 16,
    parameter int POTW = 12,
    parameter int AW   = 21
) (
    input  logic signed [DW-1:0]     i_a,
    input  logic        [2*POTW-1:0] i_b,
    input  logic                     i_vol_mode,
    output logic signed [AW-1:0]     o_term,
    output logic signed [DW-1:0]     o_sat,
    output logic                     o_clip
);

    localparam int PW = DW + 2 * POTW + 1;

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;
    logic signed [XW-1:0] w_wide;

    assign w_a_ext = PW'(i_a);
    assign w_b_ext = PW'($signed({1'b0, i_b}));
    assign w_prod  = w_a_ext * w_b_ext;

    // Gain terms drop 2*POTW-1 bits (full pot is ~2x); volume drops POTW bits.
    always_comb begin
        if (i_vol_mode) begin
            w_shift = w_prod >>> POTW;
        end else begin
            w_shift = w_prod >>> (2 * POTW - 1);
        end
    end

    assign w_wide = XW'(w_shift);
    assign o_term = AW'(w_shift);
    assign o_sat  = DW'(sat_to(w_wide, DW));
    assign o_clip = clip_to(w_wide, DW);

endmodule

// File: rtl/eq_mix_engine.sv
// Multi-channel band gain/sum stage with ramped volume and amplifier idle timeout,
// time-multiplexed over a single shared multiplier.
module eq_mix_engine
    import eq_mix_engine_pkg::*;
#(
    parameter int N_BANDS    = 5,
    parameter int N_CH       = 2,
    parameter int DW         = 16,
    parameter int POTW       = 12,
    parameter int VOL_STEP   = 16,
    parameter int IDLE_SMPLS = 48000
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_band_vld,
    input  logic [N_CH*N_BANDS*DW-1:0]  i_band_smpl,
    input  logic [N_BANDS*POTW-1:0]     i_band_pot,
    input  logic [POTW-1:0]             i_pot_vol,
    output logic [N_CH*DW-1:0]          o_out_smpl,
    output logic                        o_out_vld,
    output logic                        o_busy,
    output logic                        o_drop,
    output logic                        o_sat,
    output logic                        o_amp_on
);

    localparam int NS = N_CH * N_BANDS;
    localparam int AW = acc_width(DW, N_BANDS);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int IW = $clog2(IDLE_SMPLS + 1);
    localparam logic        [POTW-1:0] STEP_U = POTW'(VOL_STEP);
    localparam logic signed [POTW+1:0] STEP_S = (POTW + 2)'(VOL_STEP);

    state_t                r_state;
    logic [NS*DW-1:0]      r_smpl;
    logic [N_BANDS*POTW-1:0] r_pot;
    logic [POTW-1:0]       r_vol_eff;
    logic signed [AW-1:0]  r_acc [N_CH];
    logic [N_CH*DW-1:0]    r_res;
    logic                  r_clip;
    logic [CW-1:0]         r_ch;
    logic [BW-1:0]         r_band;
    logic [IW-1:0]         r_idle_cnt;

    int                    w_idx;
    logic signed [DW-1:0]  w_smpl;
    logic [POTW-1:0]       w_pot;
    logic [2*POTW-1:0]     w_gain;
    logic signed [AW-1:0]  w_acc_cur;
    logic signed [DW-1:0]  w_mix;
    logic                  w_mix_clip;
    logic signed [DW-1:0]  w_mul_a;
    logic [2*POTW-1:0]     w_mul_b;
    logic                  w_vol_mode;
    logic signed [AW-1:0]  w_term;
    logic signed [DW-1:0]  w_mul_sat;
    logic                  w_mul_clip;
    logic                  w_any_clip;
    logic [N_CH*DW-1:0]    w_res_full;
    logic signed [POTW+1:0] w_vol_diff;
    logic [POTW-1:0]       w_vol_next;

    // Operand selection for the current channel/band and mix of the current channel.
    always_comb begin
        w_idx     = smpl_idx(int'(r_ch), int'(r_band), N_BANDS);
        w_smpl    = '0;
        w_pot     = '0;
        w_acc_cur = '0;
        for (int i = 0; i < NS; i++) begin
            w_smpl = (i == w_idx) ? r_smpl[i*DW +: DW] : w_smpl;
        end
        for (int b = 0; b < N_BANDS; b++) begin
            w_pot = (b == int'(r_band)) ? r_pot[b*POTW +: POTW] : w_pot;
        end
        for (int c = 0; c < N_CH; c++) begin
            w_acc_cur = (c == int'(r_ch)) ? r_acc[c] : w_acc_cur;
        end
        w_gain     = (2 * POTW)'(w_pot) * (2 * POTW)'(w_pot);
        w_mix      = DW'(sat_to(XW'(w_acc_cur), DW));
        w_mix_clip = clip_to(XW'(w_acc_cur), DW);
        w_vol_mode = (r_state == ST_VOL);
        if (w_vol_mode) begin
            w_mul_a = w_mix;
            w_mul_b = (2 * POTW)'(r_vol_eff);
        end else begin
            w_mul_a = w_smpl;
            w_mul_b = w_gain;
        end
    end

    eq_mix_engine_sat_mul #(
        .DW   (DW),
        .POTW (POTW),
        .AW   (AW)
    ) u_sat_mul (
        .i_a        (w_mul_a),
        .i_b        (w_mul_b),
        .i_vol_mode (w_vol_mode),
        .o_term     (w_term),
        .o_sat      (w_mul_sat),
        .o_clip     (w_mul_clip)
    );

    // Result vector with the channel being finished merged in, plus the clamped volume step.
    always_comb begin
        w_any_clip = w_mix_clip | w_mul_clip;
        w_res_full = r_res;
        for (int c = 0; c < N_CH; c++) begin
            w_res_full[c*DW +: DW] = (c == int'(r_ch)) ? w_mul_sat : r_res[c*DW +: DW];
        end
        w_vol_diff = $signed({2'b00, i_pot_vol}) - $signed({2'b00, r_vol_eff});
        if (w_vol_diff > STEP_S) begin
            w_vol_next = r_vol_eff + STEP_U;
        end else if (w_vol_diff < -STEP_S) begin
            w_vol_next = r_vol_eff - STEP_U;
        end else begin
            w_vol_next = i_pot_vol;
        end
    end

    // Sequencer: latch, band MAC, per-channel volume, output and amplifier idle tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_smpl     <= '0;
            r_pot      <= '0;
            r_vol_eff  <= '0;
            r_res      <= '0;
            r_clip     <= 1'b0;
            r_ch       <= '0;
            r_band     <= '0;
            r_idle_cnt <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_acc[c] <= '0;
            end
            o_out_smpl <= '0;
            o_out_vld  <= 1'b0;
            o_busy     <= 1'b0;
            o_drop     <= 1'b0;
            o_sat      <= 1'b0;
            o_amp_on   <= 1'b0;
        end else begin
            o_out_vld <= 1'b0;
            o_sat     <= 1'b0;
            o_drop    <= i_band_vld && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (i_band_vld) begin
                        r_smpl    <= i_band_smpl;
                        r_pot     <= i_band_pot;
                        r_vol_eff <= w_vol_next;
                        r_clip    <= 1'b0;
                        r_ch      <= '0;
                        r_band    <= '0;
                        for (int c = 0; c < N_CH; c++) begin
                            r_acc[c] <= '0;
                        end
                        o_busy    <= 1'b1;
                        r_state   <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (c == int'(r_ch)) begin
                            r_acc[c] <= r_acc[c] + w_term;
                        end
                    end
                    if (r_band == BW'(N_BANDS - 1)) begin
                        r_band <= '0;
                        if (r_ch == CW'(N_CH - 1)) begin
                            r_ch    <= '0;
                            r_state <= ST_VOL;
                        end else begin
                            r_ch <= r_ch + CW'(1);
                        end
                    end else begin
                        r_band <= r_band + BW'(1);
                    end
                end
                ST_VOL: begin
                    r_res  <= w_res_full;
                    r_clip <= r_clip | w_any_clip;
                    if (r_ch == CW'(N_CH - 1)) begin
                        r_ch       <= '0;
                        o_out_smpl <= w_res_full;
                        o_out_vld  <= 1'b1;
                        o_sat      <= r_clip | w_any_clip;
                        r_state    <= ST_DONE;
                    end else begin
                        r_ch <= r_ch + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (|o_out_smpl) begin
                        o_amp_on   <= 1'b1;
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt >= IW'(IDLE_SMPLS - 1)) begin
                        r_idle_cnt <= IW'(IDLE_SMPLS);
                        o_amp_on   <= 1'b0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IW'(1);
                    end
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
